// File: rtl/seq_pkg.sv
// ---------------------------------------------------------------------------
// seq_pkg
// Shared definitions for the merge-sort run-distribution front end.
//   DW, L, RCW : default element width, output FIFO depth, run counter width
//   route_t    : which output stream a run is being written to
//   flip_route : the other output stream
// ---------------------------------------------------------------------------
package seq_pkg;

    localparam int DW  = 8;
    localparam int L   = 16;
    localparam int RCW = 16;

    typedef enum logic {
        SEL_A = 1'b0,
        SEL_B = 1'b1
    } route_t;

    function automatic route_t flip_route(input route_t r);
        return (r == SEL_A) ? SEL_B : SEL_A;
    endfunction

endpackage

// File: rtl/seq_splitter_if.sv
// ---------------------------------------------------------------------------
// seq_splitter_if
// Bundles the input element stream, both output streams and the run counter
// of seq_splitter.
//   data_i/req_i/sos_i -> ack_i       : input stream (ack_i driven by splitter)
//   data_a/req_a       -> ack_a       : output stream A (ack_a from consumer)
//   data_b/req_b       -> ack_b       : output stream B (ack_b from consumer)
//   run_cnt                           : runs started since reset or sos_i
// Modports: slave = splitter side, master = producer/consumer side.
// ---------------------------------------------------------------------------
interface seq_splitter_if #(
    parameter int dw  = seq_pkg::DW,
    parameter int RCW = seq_pkg::RCW
);
    logic [dw-1:0]  data_i;
    logic           req_i;
    logic           sos_i;
    logic           ack_i;

    logic [dw-1:0]  data_a;
    logic           req_a;
    logic           ack_a;

    logic [dw-1:0]  data_b;
    logic           req_b;
    logic           ack_b;

    logic [RCW-1:0] run_cnt;

    modport slave (
        input  data_i, req_i, sos_i, ack_a, ack_b,
        output ack_i, data_a, req_a, data_b, req_b, run_cnt
    );

    modport master (
        output data_i, req_i, sos_i, ack_a, ack_b,
        input  ack_i, data_a, req_a, data_b, req_b, run_cnt
    );

endinterface

// File: rtl/split_fifo.sv
// ---------------------------------------------------------------------------
// split_fifo
// First-word-fall-through FIFO buffering one output stream of seq_splitter.
//   clk, rst           : clock, asynchronous active-high reset
//   din/din_req/din_ack: write side; din_ack = not full
//   dout               : current head entry (raw; meaningful when dout_req=1)
//   dout_req/dout_ack  : read side; dout_req = not empty, pop on req & ack
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// ---------------------------------------------------------------------------
module split_fifo #(
    parameter int dw = seq_pkg::DW,
    parameter int L  = seq_pkg::L
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [dw-1:0] din,
    input  logic          din_req,
    output logic          din_ack,
    output logic [dw-1:0] dout,
    output logic          dout_req,
    input  logic          dout_ack
);

    localparam int AW = $clog2(L);

    logic [dw-1:0] mem_q [L];
    logic [AW:0]   wr_ptr_q;
    logic [AW:0]   rd_ptr_q;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A full FIFO refuses a write even when it is popped in the same cycle,
    // so din_ack never depends on dout_ack.
    assign din_ack  = !full;
    assign dout_req = !empty;
    assign push     = din_req && !full;
    assign pop      = dout_ack && !empty;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    // NOTE: the storage array is deliberately not reset; clearing the
    // pointers already makes every entry invisible, and a resettable array
    // cannot map onto RAM.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

    assign dout = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/seq_splitter.sv
// ---------------------------------------------------------------------------
// seq_splitter
// Splits one element stream into two, sending each maximal non-decreasing
// run alternately to output A and output B, each behind its own FIFO.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : seq_splitter_if.slave (input stream, outputs A/B, run_cnt)
// Only data_i/req_i/sos_i -> ack_i is combinational; outputs come straight
// from FIFO state, giving one cycle of latency.
// ---------------------------------------------------------------------------
module seq_splitter
    import seq_pkg::*;
#(
    parameter int dw  = seq_pkg::DW,
    parameter int L   = seq_pkg::L,
    parameter int RCW = seq_pkg::RCW
) (
    input  logic          clk,
    input  logic          rst,
    seq_splitter_if.slave bus
);

    route_t         sel_q;
    route_t         sel_d;
    logic [dw-1:0]  prev_q;
    logic           have_prev_q;
    logic [RCW-1:0] run_cnt_q;
    logic [RCW-1:0] run_cnt_d;

    route_t         target;
    logic           new_run;
    logic           xfer;

    logic           ack_fa;
    logic           ack_fb;
    logic [dw-1:0]  head_a;
    logic [dw-1:0]  head_b;
    logic           nonempty_a;
    logic           nonempty_b;

    // Route decision: a value smaller than the previous one closes the run
    // and switches outputs; equal values continue the current run.
    // NOTE: every signal gets a default at the top of the block so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        target  = sel_q;
        new_run = 1'b0;
        if (bus.sos_i || !have_prev_q) begin
            target  = SEL_A;
            new_run = 1'b1;
        end else if (bus.data_i < prev_q) begin
            target  = flip_route(sel_q);
            new_run = 1'b1;
        end
    end

    assign bus.ack_i = (target == SEL_A) ? ack_fa : ack_fb;
    assign xfer      = bus.req_i && bus.ack_i;

    always_comb begin
        sel_d     = sel_q;
        run_cnt_d = run_cnt_q;
        if (xfer) begin
            sel_d = target;
            if (bus.sos_i)    run_cnt_d = RCW'(1);
            else if (new_run) run_cnt_d = run_cnt_q + RCW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q       <= SEL_A;
            prev_q      <= '0;
            have_prev_q <= 1'b0;
            run_cnt_q   <= '0;
        end else begin
            sel_q     <= sel_d;
            run_cnt_q <= run_cnt_d;
            if (xfer) begin
                prev_q      <= bus.data_i;
                have_prev_q <= 1'b1;
            end
        end
    end

    split_fifo #(.dw(dw), .L(L)) u_fifo_a (
        .clk      (clk),
        .rst      (rst),
        .din      (bus.data_i),
        .din_req  (bus.req_i && (target == SEL_A)),
        .din_ack  (ack_fa),
        .dout     (head_a),
        .dout_req (nonempty_a),
        .dout_ack (bus.ack_a)
    );

    split_fifo #(.dw(dw), .L(L)) u_fifo_b (
        .clk      (clk),
        .rst      (rst),
        .din      (bus.data_i),
        .din_req  (bus.req_i && (target == SEL_B)),
        .din_ack  (ack_fb),
        .dout     (head_b),
        .dout_req (nonempty_b),
        .dout_ack (bus.ack_b)
    );

    // Empty FIFOs present 0 rather than a stale RAM entry.
    assign bus.req_a   = nonempty_a;
    assign bus.req_b   = nonempty_b;
    assign bus.data_a  = nonempty_a ? head_a : '0;
    assign bus.data_b  = nonempty_b ? head_b : '0;
    assign bus.run_cnt = run_cnt_q;

endmodule

// File: tb/tb_seq_splitter.sv
// ---------------------------------------------------------------------------
// tb_seq_splitter
// Directed bench for seq_splitter. Inputs change 1 time unit after a rising
// edge and outputs are sampled 1 time unit later, well away from the edge.
// ---------------------------------------------------------------------------
module tb_seq_splitter;

    logic clk;
    logic rst;

    int total;
    int bad;

    seq_splitter_if #(.dw(8), .RCW(16)) bus ();

    seq_splitter #(.dw(8), .L(16), .RCW(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Leaves time at rising edge + 1.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.req_i = 1'b0;
        bus.sos_i = 1'b0;
        bus.data_i = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Offer one element, require it to be accepted, and let one edge pass.
    task automatic send(input logic [7:0] v, input logic sos, input string tag);
        bus.data_i = v;
        bus.sos_i  = sos;
        bus.req_i  = 1'b1;
        #1;
        check({tag, "_ack"}, 32'(bus.ack_i), 32'd1);
        tick();
        bus.req_i = 1'b0;
        bus.sos_i = 1'b0;
    endtask

    // Split vectors: value, expected output (0=A,1=B), expected run_cnt.
    logic [7:0]  split_v   [7] = '{8'd3, 8'd5, 8'd5, 8'd9, 8'd2, 8'd4, 8'd1};
    logic        split_sd  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [15:0] split_cnt [7] = '{16'd1, 16'd1, 16'd1, 16'd1, 16'd2, 16'd2, 16'd3};

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1;
        bus.data_i = '0;
        bus.req_i  = 1'b0;
        bus.sos_i  = 1'b0;
        bus.ack_a  = 1'b0;
        bus.ack_b  = 1'b0;

        // ---------------- reset state ----------------
        do_reset();
        #1;
        check("rst_req_a", 32'(bus.req_a), 32'd0);
        check("rst_req_b", 32'(bus.req_b), 32'd0);
        check("rst_data_a", 32'(bus.data_a), 32'd0);
        check("rst_data_b", 32'(bus.data_b), 32'd0);
        check("rst_ack_i", 32'(bus.ack_i), 32'd1);
        check("rst_run_cnt", 32'(bus.run_cnt), 32'd0);

        // ---------------- run split, sinks ready ----------------
        bus.ack_a = 1'b1;
        bus.ack_b = 1'b1;
        for (int i = 0; i < 7; i++) begin
            send(split_v[i], 1'b0, $sformatf("split%0d", i));
            if (split_sd[i]) begin
                check($sformatf("split%0d_req_b", i), 32'(bus.req_b), 32'd1);
                check($sformatf("split%0d_data_b", i), 32'(bus.data_b), 32'(split_v[i]));
            end else begin
                check($sformatf("split%0d_req_a", i), 32'(bus.req_a), 32'd1);
                check($sformatf("split%0d_data_a", i), 32'(bus.data_a), 32'(split_v[i]));
            end
            check($sformatf("split%0d_cnt", i), 32'(bus.run_cnt), 32'(split_cnt[i]));
        end
        tick();
        check("split_drained_a", 32'(bus.req_a), 32'd0);
        check("split_drained_b", 32'(bus.req_b), 32'd0);

        // ---------------- B full ----------------
        do_reset();
        bus.ack_a = 1'b0;
        bus.ack_b = 1'b0;
        send(8'd10, 1'b0, "bfull_10");
        for (int i = 0; i < 16; i++) send(8'(i), 1'b0, $sformatf("bfull_fill%0d", i));
        check("bfull_cnt", 32'(bus.run_cnt), 32'd2);
        bus.data_i = 8'd16;
        bus.req_i  = 1'b1;
        #1;
        check("bfull_stall", 32'(bus.ack_i), 32'd0);
        check("bfull_a_req", 32'(bus.req_a), 32'd1);
        check("bfull_a_data", 32'(bus.data_a), 32'd10);
        check("bfull_b_head", 32'(bus.data_b), 32'd0);
        bus.ack_a = 1'b1;
        tick();
        bus.ack_a = 1'b0;
        #1;
        check("bfull_a_drained", 32'(bus.req_a), 32'd0);
        check("bfull_still_stall", 32'(bus.ack_i), 32'd0);
        bus.ack_b = 1'b1;
        #1;
        check("bfull_pop_cycle_stall", 32'(bus.ack_i), 32'd0);
        tick();
        bus.ack_b = 1'b0;
        #1;
        check("bfull_after_pop_head", 32'(bus.data_b), 32'd1);
        check("bfull_after_pop_ack", 32'(bus.ack_i), 32'd1);
        tick();
        bus.req_i = 1'b0;
        bus.ack_b = 1'b1;
        #1;
        for (int i = 1; i <= 16; i++) begin
            check($sformatf("bfull_drain%0d_req", i), 32'(bus.req_b), 32'd1);
            check($sformatf("bfull_drain%0d", i), 32'(bus.data_b), 32'(i));
            tick();
        end
        check("bfull_b_empty", 32'(bus.req_b), 32'd0);
        check("bfull_b_zero", 32'(bus.data_b), 32'd0);

        // ---------------- start of sequence ----------------
        do_reset();
        bus.ack_a = 1'b1;
        bus.ack_b = 1'b1;
        send(8'd7, 1'b0, "sos_7");
        send(8'd3, 1'b0, "sos_3");
        check("sos_3_data_b", 32'(bus.data_b), 32'd3);
        check("sos_3_cnt", 32'(bus.run_cnt), 32'd2);
        send(8'd5, 1'b1, "sos_5");
        check("sos_5_req_a", 32'(bus.req_a), 32'd1);
        check("sos_5_data_a", 32'(bus.data_a), 32'd5);
        check("sos_5_cnt", 32'(bus.run_cnt), 32'd1);
        send(8'd4, 1'b0, "sos_4");
        check("sos_4_req_b", 32'(bus.req_b), 32'd1);
        check("sos_4_data_b", 32'(bus.data_b), 32'd4);
        check("sos_4_cnt", 32'(bus.run_cnt), 32'd2);
        tick();

        // ---------------- reset mid-stream ----------------
        do_reset();
        bus.ack_a = 1'b0;
        bus.ack_b = 1'b0;
        for (int i = 1; i <= 4; i++) send(8'(i), 1'b0, $sformatf("mid_fill%0d", i));
        check("mid_req_a_before", 32'(bus.req_a), 32'd1);
        check("mid_data_a_before", 32'(bus.data_a), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_req_a_async", 32'(bus.req_a), 32'd0);
        check("mid_data_a_async", 32'(bus.data_a), 32'd0);
        check("mid_cnt_async", 32'(bus.run_cnt), 32'd0);
        tick();
        rst = 1'b0;
        send(8'd6, 1'b0, "mid_6");
        check("mid_6_data_a", 32'(bus.data_a), 32'd6);
        check("mid_6_cnt", 32'(bus.run_cnt), 32'd1);
        bus.ack_a = 1'b1;
        tick();
        check("mid_only_6", 32'(bus.req_a), 32'd0);

        // ---------------- streaming ----------------
        do_reset();
        bus.ack_a = 1'b1;
        bus.ack_b = 1'b1;
        for (int i = 0; i < 32; i++) begin
            send(8'(2 * i + 1), 1'b0, $sformatf("stream%0d", i));
            check($sformatf("stream%0d_data_a", i), 32'(bus.data_a), 32'(2 * i + 1));
            check($sformatf("stream%0d_req_b", i), 32'(bus.req_b), 32'd0);
        end
        check("stream_cnt", 32'(bus.run_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
